// File: rtl/irq_vector_capture.sv
// Synchronises an active-low 8-to-3 priority-encoder output, qualifies a stable code
// and hands it to a consumer as a true-polarity level through a req/ack handshake.
module irq_vector_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       enc_a,
   input  logic             enc_gs,
   input  logic             irq_ack,
   output logic             irq_req,
   output logic [2:0]       irq_level,
   output logic             irq_busy,
   output logic [CNT_W-1:0] svc_count
);

   localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [QW-1:0] CNT_LAST = QW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, QUALIFY, PENDING, WAIT_RELEASE} state_t;

   state_t        state;
   logic [2:0]    a_meta, a_s;
   logic          gs_meta, gs_s;
   logic [2:0]    cand;
   logic [QW-1:0] cnt;
   logic [2:0]    code;

   assign code = ~a_s;

   // Synchronisers reset to the inactive encoder output so reset never looks like a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_meta  <= 3'b111;
         a_s     <= 3'b111;
         gs_meta <= 1'b1;
         gs_s    <= 1'b1;
      end else begin
         a_meta  <= enc_a;
         a_s     <= a_meta;
         gs_meta <= enc_gs;
         gs_s    <= gs_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= 3'd0;
         cnt       <= '0;
         irq_req   <= 1'b0;
         irq_level <= 3'd0;
         irq_busy  <= 1'b0;
         svc_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!gs_s) begin
                  state    <= QUALIFY;
                  cand     <= code;
                  cnt      <= '0;
                  irq_busy <= 1'b1;
               end
            end
            QUALIFY: begin
               if (gs_s) begin
                  state    <= IDLE;
                  irq_busy <= 1'b0;
               end else if (code != cand) begin
                  cand <= code;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= PENDING;
                  irq_level <= cand;
                  irq_req   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PENDING: begin
               // Level is frozen here; a higher code is only looked at after service.
               if (irq_ack) begin
                  state     <= WAIT_RELEASE;
                  irq_req   <= 1'b0;
                  cnt       <= '0;
                  svc_count <= svc_count + 1'b1;
               end
            end
            WAIT_RELEASE: begin
               if (!gs_s) begin
                  if (code != irq_level) begin
                     state <= QUALIFY;
                     cand  <= code;
                  end
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  irq_busy <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               irq_req  <= 1'b0;
               irq_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
